serial_add_ctrl: RTL and testbench

- Bit-serial add/subtract sequencer that time-shares one single-bit full-adder cell (majority carry + parity sum) across a WIDTH-bit operation.
- The cell is processed LSB first, one bit per clock, with the carry held in a flip-flop between bits.
- Sits between a requesting unit (start/done handshake) and the adder cell, and replaces a WIDTH-wide ripple adder where area matters more than latency.

---
 rtl/serial_add_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell time-shared
// over WIDTH bits, LSB first, with the carry held between bits.
module serial_add_fa (
  input  logic x_i,
  input  logic y_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);
  assign s_o    = x_i ^ y_i ^ cin_i;
  assign cout_o = (x_i & y_i) | (x_i & cin_i) | (y_i & cin_i);
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;
  logic             cell_s;
  logic             cell_c;
  logic             last;

  serial_add_fa u_fa (
    .x_i    (opa_q[0]),
    .y_i    (opb_q[0]),
    .cin_i  (carry_q),
    .s_o    (cell_s),
    .cout_o (cell_c)
  );

  assign acc_d = {cell_s, acc_q[WIDTH-1:1]};
  assign last  = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            opa_q   <= a;
            opb_q   <= b ^ {WIDTH{sub}};
            carry_q <= sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          opa_q   <= opa_q >> 1;
          opb_q   <= opb_q >> 1;
          acc_q   <= acc_d;
          carry_q <= cell_c;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            // carry into MSB xor carry out of MSB flags signed overflow
            sum_q   <= acc_d;
            cout_q  <= cell_c;
            ovf_q   <= carry_q ^ cell_c;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: WIDTH=8 and WIDTH=2 instances.
module tb_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  logic       st2;
  logic       sub2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       busy2;
  logic       done2;
  logic [1:0] sum2;
  logic       cout2;
  logic       ovf2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .start (st2),
    .sub   (sub2),
    .a     (a2),
    .b     (b2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2),
    .ovf   (ovf2)
  );

  // lat = negedges after the launch edge until done is seen; 0 on timeout
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib,
                      input logic is, output int lat);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; sub = is;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run2(input logic [1:0] ia, input logic [1:0] ib,
                      input logic is, output int lat);
    @(negedge clk);
    st2 = 1'b1; a2 = ia; b2 = ib; sub2 = is;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      st2 = 1'b0;
      if (done2) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    st2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, sum, cout, ovf} !== 11'd0) begin
      errors++;
      $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               busy, done, sum, cout, ovf);
    end
    checks++;
    if ({busy2, done2, sum2, cout2, ovf2} !== 5'd0) begin
      errors++;
      $display("FAIL reset2: got busy=%b done=%b sum=%b cout=%b ovf=%b want all 0",
               busy2, done2, sum2, cout2, ovf2);
    end
  endtask

  task automatic test_basic();
    logic exp_busy;
    logic exp_done;
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h3C; sub = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start = 1'b0;
      exp_busy = (n <= 8);
      exp_done = (n == 9);
      checks++;
      if (busy !== exp_busy || done !== exp_done) begin
        errors++;
        $display("FAIL basic_hs n=%0d: got busy=%b done=%b want busy=%b done=%b",
                 n, busy, done, exp_busy, exp_done);
      end
      if (n == 4) begin
        checks++;
        if (sum !== 8'h00) begin
          errors++;
          $display("FAIL basic_hold: got sum=%h want 00", sum);
        end
      end
      if (n == 9) begin
        checks++;
        if (sum !== 8'h96 || cout !== 1'b0 || ovf !== 1'b1) begin
          errors++;
          $display("FAIL basic_res: got sum=%h cout=%b ovf=%b want 96 0 1",
                   sum, cout, ovf);
        end
      end
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [4] = '{8'hFF, 8'h7F, 8'h10, 8'h80};
    logic [7:0] vb [4] = '{8'h01, 8'h01, 8'h20, 8'h01};
    logic       vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] es [4] = '{8'h00, 8'h80, 8'hF0, 8'h7F};
    logic       ec [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       eo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run8(va[i], vb[i], vs[i], lat);
      checks++;
      if (lat != 9) begin
        errors++;
        $display("FAIL vec%0d_lat: got %0d want 9", i, lat);
      end
      checks++;
      if (sum !== es[i] || cout !== ec[i] || ovf !== eo[i]) begin
        errors++;
        $display("FAIL vec%0d_res: got sum=%h cout=%b ovf=%b want %h %b %b",
                 i, sum, cout, ovf, es[i], ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dcnt = 0;
    int d1 = 0;
    int d2 = 0;
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h3C; sub = 1'b0;
    for (int n = 1; n <= 19; n++) begin
      @(negedge clk);
      if (n == 1) begin
        a = 8'h00; b = 8'h00;
      end
      if (done) begin
        dcnt++;
        if (dcnt == 1) d1 = n;
        if (dcnt == 2) d2 = n;
        if (dcnt == 1) begin
          checks++;
          if (sum !== 8'h96) begin
            errors++;
            $display("FAIL b2b_first: got sum=%h want 96", sum);
          end
        end
      end
      if (n == 14) begin
        checks++;
        if (sum !== 8'h96 || busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_hold: got sum=%h busy=%b want 96 1", sum, busy);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (dcnt != 2 || d1 != 9 || d2 != 19) begin
      errors++;
      $display("FAIL b2b_pulses: got cnt=%0d at %0d,%0d want 2 at 9,19",
               dcnt, d1, d2);
    end
    checks++;
    if (sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got sum=%h cout=%b ovf=%b want 00 0 0",
               sum, cout, ovf);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat;
    int dcnt = 0;
    run8(8'h5A, 8'h3C, 1'b0, lat);
    checks++;
    if (lat != 9 || sum !== 8'h96) begin
      errors++;
      $display("FAIL abort_pre: got lat=%0d sum=%h want 9 96", lat, sum);
    end
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h01; sub = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, sum, cout, ovf} !== 11'd0) begin
      errors++;
      $display("FAIL abort_clr: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               busy, done, sum, cout, ovf);
    end
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    checks++;
    if (dcnt != 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", dcnt);
    end
    run8(8'h03, 8'h04, 1'b0, lat);
    checks++;
    if (lat != 9 || sum !== 8'h07 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL abort_fresh: got lat=%0d sum=%h cout=%b ovf=%b want 9 07 0 0",
               lat, sum, cout, ovf);
    end
  endtask

  task automatic test_width2();
    logic [1:0] va [3] = '{2'b11, 2'b01, 2'b01};
    logic [1:0] vb [3] = '{2'b01, 2'b01, 2'b10};
    logic       vs [3] = '{1'b0, 1'b0, 1'b1};
    logic [1:0] es [3] = '{2'b00, 2'b10, 2'b11};
    logic       ec [3] = '{1'b1, 1'b0, 1'b0};
    logic       eo [3] = '{1'b0, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run2(va[i], vb[i], vs[i], lat);
      checks++;
      if (lat != 3) begin
        errors++;
        $display("FAIL w2_%0d_lat: got %0d want 3", i, lat);
      end
      checks++;
      if (sum2 !== es[i] || cout2 !== ec[i] || ovf2 !== eo[i]) begin
        errors++;
        $display("FAIL w2_%0d_res: got sum=%b cout=%b ovf=%b want %b %b %b",
                 i, sum2, cout2, ovf2, es[i], ec[i], eo[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_reset_abort();
    test_width2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
